// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial front end for the bit-serial sequence
// detectors. Words arrive over a valid/ready handshake and leave one bit per
// clock on sout, back to back with no idle gap between consecutive words.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no word in flight; sout/sout_valid held at 0, ready for a word
// S_SHIFT | sout carries bit cnt of the word in sreg; reload allowed at last bit
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             abort,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sreg, w_sreg_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_sout, w_sout_nxt;
  logic             r_sout_valid, w_sout_valid_nxt;

  logic             w_last;
  logic             w_first_bit;
  logic             w_next_bit;
  logic [WIDTH-1:0] w_shifted;

  assign w_last = (r_state == S_SHIFT) && (r_cnt == LAST);

  // The bit that follows the current one sits next to the output end of sreg;
  // sreg is shifted once per emitted bit so the output end always leads.
  assign w_first_bit = MSB_FIRST ? din[WIDTH-1]    : din[0];
  assign w_next_bit  = MSB_FIRST ? r_sreg[WIDTH-2] : r_sreg[1];
  assign w_shifted   = MSB_FIRST ? {r_sreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_sreg[WIDTH-1:1]};

  // Ready in IDLE or on the last bit so the next word follows with no gap;
  // abort always wins and nothing is accepted while reset is held.
  assign din_ready = reset_n && !abort && ((r_state == S_IDLE) || w_last);

  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;
  assign busy       = (r_state == S_SHIFT);

  // State, shift register, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_sreg       <= '0;
      r_cnt        <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sreg       <= w_sreg_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_sout_valid_nxt;
    end
  end

  // Next-state: load on handshake, shift while bits remain, drop to IDLE
  // (with a defined 0 on sout) at the end of a word or on abort.
  always_comb begin
    w_state_nxt      = r_state;
    w_sreg_nxt       = r_sreg;
    w_cnt_nxt        = r_cnt;
    w_sout_nxt       = r_sout;
    w_sout_valid_nxt = r_sout_valid;

    if (abort) begin
      w_state_nxt      = S_IDLE;
      w_sout_nxt       = 1'b0;
      w_sout_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_sout_nxt       = 1'b0;
          w_sout_valid_nxt = 1'b0;
          if (din_valid) begin
            w_state_nxt      = S_SHIFT;
            w_sreg_nxt       = din;
            w_cnt_nxt        = '0;
            w_sout_nxt       = w_first_bit;
            w_sout_valid_nxt = 1'b1;
          end
        end
        S_SHIFT: begin
          if (r_cnt != LAST) begin
            w_cnt_nxt        = r_cnt + CW'(1);
            w_sreg_nxt       = w_shifted;
            w_sout_nxt       = w_next_bit;
            w_sout_valid_nxt = 1'b1;
          end else if (din_valid) begin
            w_sreg_nxt       = din;
            w_cnt_nxt        = '0;
            w_sout_nxt       = w_first_bit;
            w_sout_valid_nxt = 1'b1;
          end else begin
            w_state_nxt      = S_IDLE;
            w_sout_nxt       = 1'b0;
            w_sout_valid_nxt = 1'b0;
          end
        end
        default: begin
          w_state_nxt      = S_IDLE;
          w_sout_nxt       = 1'b0;
          w_sout_valid_nxt = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: one MSB-first and one LSB-first instance share
// the handshake controls; a queue-of-bits reference model predicts both.
module tb_serial_bit_source;

  logic       clk;
  logic       reset_n;
  logic [7:0] din_m, din_l;
  logic       din_valid;
  logic       abort;
  logic       rdy_m, sout_m, sv_m, busy_m;
  logic       rdy_l, sout_l, sv_l, busy_l;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset_n(reset_n), .din(din_m), .din_valid(din_valid),
    .din_ready(rdy_m), .abort(abort), .sout(sout_m), .sout_valid(sv_m),
    .busy(busy_m)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset_n(reset_n), .din(din_l), .din_valid(din_valid),
    .din_ready(rdy_l), .abort(abort), .sout(sout_l), .sout_valid(sv_l),
    .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the bits still to appear on sout, current bit first.
  bit qm[$];
  bit ql[$];

  logic obs_sm, obs_vm, obs_rm, obs_bm;

  typedef struct {
    bit         v;
    logic [7:0] dm;
    logic [7:0] dl;
    bit         a;
    bit         es;
    bit         ev;
    bit         er;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_edge(bit v, logic [7:0] dm, logic [7:0] dl, bit a);
    bit rdy;
    rdy = !a && (qm.size() <= 1);
    if (a) begin
      qm.delete();
      ql.delete();
    end else if (v && rdy) begin
      qm.delete();
      ql.delete();
      for (int i = 0; i < 8; i++) begin
        qm.push_back(dm[7-i]);
        ql.push_back(dl[i]);
      end
    end else if (qm.size() > 0) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
  endfunction

  // Called at a falling edge: drive inputs, sample and optionally check
  // against the model, then advance the model across the rising edge.
  task automatic cycle(input bit v, input logic [7:0] dm, input logic [7:0] dl,
                       input bit a, input bit use_model);
    bit er;
    din_valid = v;
    din_m     = dm;
    din_l     = dl;
    abort     = a;
    #1;
    obs_sm = sout_m;
    obs_vm = sv_m;
    obs_rm = rdy_m;
    obs_bm = busy_m;
    if (use_model) begin
      er = reset_n && !a && (qm.size() <= 1);
      chk("m_sout",  sout_m, (qm.size() > 0) ? qm[0] : 1'b0);
      chk("m_valid", sv_m,   qm.size() > 0);
      chk("m_busy",  busy_m, qm.size() > 0);
      chk("m_ready", rdy_m,  er);
      chk("l_sout",  sout_l, (ql.size() > 0) ? ql[0] : 1'b0);
      chk("l_valid", sv_l,   ql.size() > 0);
      chk("l_busy",  busy_l, ql.size() > 0);
      chk("l_ready", rdy_l,  er);
    end
    @(posedge clk);
    model_edge(v, dm, dl, a);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  seq;
    logic [3:0]  det;
    int          hits;
    logic [15:0] stream;
    int          nbits;

    reset_n   = 1'b0;
    din_valid = 1'b1;
    din_m     = 8'hFF;
    din_l     = 8'hFF;
    abort     = 1'b0;

    // Directed single word: 1001_0000 MSB-first and 0000_1001 LSB-first both
    // produce 1,0,0,1,0,0,0,0.
    seq = 8'b1001_0000;
    tbl[0] = '{1'b1, 8'h90, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 8'h00, 8'h00, 1'b0, seq[8-i], 1'b1, (i == 8)};
    tbl[9] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sout",  sout_m, 1'b0);
    chk("rst_valid", sv_m,   1'b0);
    chk("rst_busy",  busy_m, 1'b0);
    chk("rst_ready", rdy_m,  1'b0);
    chk("rst_ready_l", rdy_l, 1'b0);
    reset_n = 1'b1;
    qm.delete();
    ql.delete();

    det  = '0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].v, tbl[i].dm, tbl[i].dl, tbl[i].a, 1'b0);
      chk("tbl_sout_m",  obs_sm, tbl[i].es);
      chk("tbl_valid_m", obs_vm, tbl[i].ev);
      chk("tbl_ready_m", obs_rm, tbl[i].er);
      chk("tbl_sout_l",  sout_l === 1'bx ? 1'bx : obs_sm, tbl[i].es);
      det = {det[2:0], obs_sm};
      if (det == 4'b1001) hits++;
    end
    n_vec++;
    if (hits != 1) begin
      n_bad++;
      $display("FAIL det1001: got %0d hits expected 1", hits);
    end
    repeat (2) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Back-to-back A5 then 3C with valid held; din wiggles while not ready.
    stream = '0;
    nbits  = 0;
    cycle(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      logic [7:0] d;
      bit         v;
      d = (i == 8) ? 8'h3C : 8'($urandom);
      v = (i <= 8);
      cycle(v, d, d, 1'b0, 1'b1);
      if (obs_vm) begin
        stream = {stream[14:0], obs_sm};
        nbits++;
      end
    end
    chk16("b2b_stream", stream, 16'hA53C);
    chk16("b2b_nbits", 16'(nbits), 16'd16);
    repeat (2) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Abort at bit index 3 of FF while a queued word waits on din.
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    cycle(1'b1, 8'h5A, 8'h5A, 1'b1, 1'b1);
    chk("abort_ready", obs_rm, 1'b0);
    chk("abort_sout_at3", obs_sm, 1'b1);
    cycle(1'b1, 8'h5A, 8'h5A, 1'b0, 1'b1);
    chk("abort_valid_next", obs_vm, 1'b0);
    chk("abort_ready_next", obs_rm, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("queued_valid", obs_vm, 1'b1);
    chk("queued_first", obs_sm, 1'b0);
    repeat (9) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset at bit index 5, between clock edges.
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    repeat (5) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sout",  sout_m, 1'b0);
    chk("arst_valid", sv_m,   1'b0);
    chk("arst_busy",  busy_m, 1'b0);
    chk("arst_ready", rdy_m,  1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    qm.delete();
    ql.delete();
    cycle(1'b1, 8'hC3, 8'hC3, 1'b0, 1'b1);
    stream = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      stream = {stream[14:0], obs_sm};
    end
    chk16("post_rst_word", stream, 16'h00C3);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      cycle($urandom_range(0, 9) < 7, d, d, $urandom_range(0, 19) == 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_bit_source.md
# serial_bit_source

Parallel-to-serial front end for the bit-serial sequence detectors. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `sout`. The `sout` output drives the detector's single-bit serial input directly. Back-to-back words stream with no idle gap, so multi-word patterns that straddle word boundaries reach the detector intact.

## Interface
- `WIDTH`, default 8: word width in bits, minimum 2.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `din`  in  WIDTH: parallel word, sampled on handshake.
- `din_valid`  in  1: producer has a word on `din`.
- `din_ready`  out  1: block accepts `din` this cycle. Handshake is `din_valid & din_ready` at a rising edge.
- `abort`  in  1: synchronous; drops the word in flight.
- `sout`  out  1: serial data bit, registered.
- `sout_valid`  out  1: `sout` carries a word bit this cycle, registered.
- `busy`  out  1: a word is being shifted (state SHIFT).

## Operation
- State machine has two states.
  - IDLE: shift register and counter are don't-care.
  - SHIFT: WIDTH-bit shift register `sreg`, bit counter `cnt` running 0..WIDTH-1, width clog2(WIDTH).
- `din_ready` is combinational:
  - 1 in IDLE.
  - 1 in SHIFT when `cnt == WIDTH-1` and `abort` is 0 (last bit on the wire).
  - 0 otherwise.
  - 0 while `reset_n` is low.
- IDLE with handshake:
  - load `sreg <= din`, `cnt <= 0`, go to SHIFT.
  - `sout` = first bit of `din` (per MSB_FIRST), `sout_valid` = 1 from the next cycle.
- SHIFT with `cnt < WIDTH-1`:
  - `cnt` increments.
  - `sreg` shifts toward the output end.
  - `sout` = next bit.
  - `sout_valid` stays 1.
- SHIFT with `cnt == WIDTH-1` and handshake:
  - reload from `din`, `cnt <= 0`, stay in SHIFT.
  - The next cycle carries bit 0 of the new word, so there is no gap.
- SHIFT with `cnt == WIDTH-1` and no handshake:
  - go to IDLE, `sout_valid <= 0`, `sout <= 0`.
- `abort` = 1, any state, no handshake possible:
  - next edge goes to IDLE, `sout <= 0`, `sout_valid <= 0`.
  - Any remaining bits of the word are discarded.
  - `din` is not accepted that cycle.
- Whenever `sout_valid` = 0, `sout` is held at 0 so the downstream detector sees a defined 0 stream.
- `din_valid` may rise or fall freely while `din_ready` = 0. Nothing is latched until a handshake occurs.

## Timing
- Reset (`reset_n` low, asynchronous):
  - state IDLE, `sreg` = 0, `cnt` = 0.
  - `sout` = 0, `sout_valid` = 0, `busy` = 0, `din_ready` = 0.
  - After release, `din_ready` = 1 in the first cycle.
- Latency: handshake at edge N puts the first bit on `sout` after edge N, and the last bit after edge N+WIDTH-1.
- Throughput: one bit per clock, continuous while `din_valid` is held high.
- Reset asserted mid-word: outputs clear immediately without waiting for a clock. The partial word is lost and no further bits are emitted.
- `abort` and `din_valid` high together: `abort` wins and the word on `din` is not consumed (`din_ready` = 0).

## Test plan
- Reset release, then one word `din=8'b1001_0000`, MSB_FIRST=1, `din_valid` pulsed one cycle:
  - `sout` = 1,0,0,1,0,0,0,0 on 8 consecutive cycles, `sout_valid` = 1 throughout.
  - Then `sout_valid` = 0, `sout` = 0.
  - A connected fsm1001-type detector flags exactly once.
- Back-to-back words `8'hA5` then `8'h3C`, `din_valid` held high:
  - 16 contiguous valid cycles with bit stream 10100101 00111100.
  - `din_ready` high only on cycle 0 and cycle 8.
- MSB_FIRST=0, `din=8'b0000_1001`: `sout` = 1,0,0,1,0,0,0,0.
- `abort` asserted at bit index 3 of `8'hFF` with `din_valid` also high:
  - `sout_valid` = 0 on the next cycle.
  - Queued word is not consumed; it loads on the following cycle.
- `reset_n` pulsed low at bit index 5, asynchronously between edges:
  - `sout` and `sout_valid` drop to 0 before the next edge.
  - After release, a fresh word serializes correctly from bit 0.
- `din_valid` held high while `busy` with `cnt` < 7: `din` changes are ignored until `cnt` = 7. The word loaded is the value present at that edge.
